// File: rtl/rv_iopmp_pkg.sv
// Shared types and defaults for the IOPMP configuration register cut.
// Default request/response structs match the default 14-bit address, 32-bit data bus.
package rv_iopmp_pkg;

    localparam int unsigned DefaultNumRegBytes   = 4096;
    localparam int unsigned DefaultTimeoutCycles = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [13:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_rsp_t;

endpackage

// File: rtl/rv_iopmp_cfg_reg_cut.sv
// Register cut between the AXI cfg abstractor and the IOPMP register file, with
// early rejection of misaligned/out-of-range accesses and a downstream timeout.
module rv_iopmp_cfg_reg_cut
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned AddrWidth     = 14,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumRegBytes   = DefaultNumRegBytes,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
    parameter type         reg_req_t     = cfg_req_t,
    parameter type         reg_rsp_t     = cfg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t slv_req_i,
    output reg_rsp_t slv_rsp_o,
    output reg_req_t mst_req_o,
    input  reg_rsp_t mst_rsp_i,
    output logic     busy_o,
    output logic     timeout_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned    CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [AddrWidth:0]  RegLimit = (AddrWidth + 1)'(NumRegBytes);

    state_e              state_q;
    reg_req_t            req_q;
    reg_rsp_t            rsp_q;
    logic [CntWidth-1:0] cnt_q;
    logic [7:0]          err_cnt_q;
    logic                timeout_q;
    logic                reject;

    assign reject = (slv_req_i.addr[1:0] != 2'b00) ||
                    ({1'b0, slv_req_i.addr} >= RegLimit);

    // Every output is taken straight from a register so the cut breaks all paths.
    assign mst_req_o = req_q;
    assign slv_rsp_o = rsp_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (slv_req_i.valid) begin
                        req_q <= slv_req_i;
                        if (reject) begin
                            req_q.valid <= 1'b0;
                            rsp_q.rdata <= {DataWidth{1'b0}};
                            rsp_q.error <= 1'b1;
                            rsp_q.ready <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            req_q.valid <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // A late ready beats the timeout when both land on the same cycle.
                    if (mst_rsp_i.ready) begin
                        req_q.valid <= 1'b0;
                        rsp_q.rdata <= req_q.write ? {DataWidth{1'b0}} : mst_rsp_i.rdata;
                        rsp_q.error <= mst_rsp_i.error;
                        rsp_q.ready <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_q == CntLast) begin
                        req_q.valid <= 1'b0;
                        rsp_q.rdata <= {DataWidth{1'b0}};
                        rsp_q.error <= 1'b1;
                        rsp_q.ready <= 1'b1;
                        timeout_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_q.ready <= 1'b0;
                    if (rsp_q.error && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_iopmp_cfg_reg_cut.md
RV_IOPMP_CFG_REG_CUT -- requirements
Module: rv_iopmp_cfg_reg_cut

Interface
REQ-001 SHALL have parameter AddrWidth, default 14: register-bus address width.
REQ-002 SHALL have parameter DataWidth, default 32: register-bus data width; wstrb width is DataWidth/8.
REQ-003 SHALL have parameter NumRegBytes, default 4096: decoded register window size in bytes; addresses >= NumRegBytes are out of range.
REQ-004 SHALL have parameter TimeoutCycles, default 255, legal range >= 1: maximum cycles to wait for downstream ready.
REQ-005 SHALL have type parameters reg_req_t (addr, write, wdata, wstrb, valid) and reg_rsp_t (rdata, error, ready).
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_i  input  1  reset, synchronous, active-high.
REQ-008 slv_req_i  input  reg_req_t  request from the AXI cfg abstractor.
REQ-009 slv_rsp_o  output  reg_rsp_t  response to the AXI cfg abstractor.
REQ-010 mst_req_o  output  reg_req_t  registered request to the IOPMP register file.
REQ-011 mst_rsp_i  input  reg_rsp_t  response from the IOPMP register file.
REQ-012 busy_o  output  1  high whenever state is not IDLE.
REQ-013 timeout_o  output  1  one-cycle pulse when a downstream access times out.
REQ-014 err_cnt_o  output  8  saturating count of error responses returned upstream.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP; the reset state is IDLE.
REQ-016 In IDLE with slv_req_i.valid=1: capture addr, write, wdata and wstrb into registers; go to RESP with error=1 and rdata=0 if addr[1:0]!=0 or addr>=NumRegBytes; otherwise go to ISSUE and clear the timeout counter.
REQ-017 In ISSUE: mst_req_o.valid=1 and the other mst_req_o fields equal the captured values; all mst_req_o fields are driven only from registers.
REQ-018 In ISSUE with mst_rsp_i.ready=1: capture mst_rsp_i.rdata (forced to 0 on writes) and mst_rsp_i.error, then go to RESP.
REQ-019 In ISSUE with ready=0: increment the counter; when the counter equals TimeoutCycles-1 and ready=0, capture error=1 and rdata=0, pulse timeout_o for one cycle, and go to RESP.
REQ-020 If ready=1 arrives in the same cycle as the timeout, ready wins: no timeout pulse and no forced error.
REQ-021 In RESP: slv_rsp_o.ready=1 for exactly one cycle with the captured rdata and error, then go to IDLE; in every other state slv_rsp_o.ready=0.
REQ-022 slv_req_i.valid still high in the cycle after RESP is treated as a new request.
REQ-023 Once captured, a request completes even if slv_req_i.valid drops; upstream field changes after capture are ignored.
REQ-024 Latency: in-range access with downstream ready in the first ISSUE cycle gives slv_rsp_o.ready 2 cycles after valid is sampled; a rejected (misaligned/out-of-range) access gives it 1 cycle after.
REQ-025 err_cnt_o increments by 1 in each RESP cycle with error=1 and saturates at 255 (no wrap).
REQ-026 Counter width SHALL be $clog2(TimeoutCycles+1) and the counter SHALL never wrap.

Reset
REQ-027 While rst_i=1: state=IDLE, mst_req_o all-zero (valid=0), slv_rsp_o all-zero (ready=0), timeout_o=0, busy_o=0, err_cnt_o=0, counter=0 and captured registers=0.
REQ-028 Reset asserted during ISSUE or RESP SHALL abandon the transaction: no upstream response and mst_req_o.valid=0 from the next edge.

Structure
REQ-029 The FSM state enum and the default NumRegBytes/TimeoutCycles constants SHALL live in rv_iopmp_pkg.
REQ-030 No sub-module is natural; the block is a single flat module with one FSM, one timeout counter and one saturating error counter.

Verification
REQ-031 Read addr=0x010, register file ready on the first ISSUE cycle with rdata=0xA5A5_0001 -> slv_rsp_o.ready 2 cycles after valid, rdata=0xA5A5_0001, error=0, err_cnt_o=0.
REQ-032 Write addr=0x012 (misaligned) -> no mst_req_o.valid, ready 1 cycle after valid, error=1, err_cnt_o=1; repeat with addr=0x1000 -> same response, err_cnt_o=2.
REQ-033 TimeoutCycles=4 and register file never ready -> mst_req_o.valid high for 4 cycles, timeout_o pulses once, response error=1, rdata=0.
REQ-034 TimeoutCycles=4 and ready asserted on the 4th ISSUE cycle -> error follows mst_rsp_i.error and timeout_o stays 0.
REQ-035 rst_i pulsed during ISSUE -> next cycle state IDLE, mst_req_o.valid=0, no slv_rsp_o.ready; 300 forced errors -> err_cnt_o=255.
